// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Two-requester arbiter in front of a single-port DataMemory. Requester 0 is
//   the CU/EU and requester 1 is the loader/debug port. Each access takes
//   three cycles: IDLE (arbitrate and latch) -> ACCESS (one memory strobe) ->
//   RESP (one-cycle ack). A burst lock lets the last owner keep the memory for
//   up to BURST_MAX back-to-back grants while the other side waits.
//
// Configuration macro: MEM_ARB_RR_EN
//   defined   : once the lock has expired or is absent, contention goes to the
//               requester that was not the last owner (round-robin).
//   undefined : once the lock has expired or is absent, contention goes to
//               requester 0 (fixed priority). This is the default build.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   req0/req1                access request
//   wr0/wr1                  1 = write, 0 = read
//   addr0/addr1 [AW]         access address
//   wdata0/wdata1 [DW]       write data
//   gnt0/gnt1                requester owns the memory (ACCESS and RESP)
//   ack0/ack1                one-cycle completion pulse (RESP)
//   rdata [DW]               read data, straight from mem_rdata, valid with ack
//   mem_addr/mem_wdata       registered memory address / write data
//   mem_rd/mem_wr            registered one-cycle memory strobes
//   mem_rdata [DW]           memory read data, valid the cycle after mem_rd
//   dbg_state [2]            current FSM state (0 IDLE, 1 ACCESS, 2 RESP)
//
// Handshake: a requester raises reqN with wrN/addrN/wdataN and holds them
// stable until the cycle in which ackN is high. The request is only sampled in
// IDLE; gntN then stays high through ACCESS and RESP, and ackN pulses in RESP.
// Keeping reqN high in the cycle after ackN is a new request. Dropping reqN
// before it is granted withdraws it with no ack.

module mem_arbiter #(
  parameter int AW        = 7,
  parameter int DW        = 8,
  parameter int BURST_MAX = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          req1,
  input  logic          wr0,
  input  logic          wr1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          ack0,
  output logic          ack1,
  output logic [DW-1:0] rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_rd,
  output logic          mem_wr,
  input  logic [DW-1:0] mem_rdata,
  output logic [1:0]    dbg_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic [3:0] BMAX = 4'(BURST_MAX);

  state_t     state;
  logic       last_owner;  // also the owner of the in-flight access
  logic       lock;        // set by a grant, cleared by an idle cycle with no request
  logic [3:0] burst_cnt;

  logic       win;
  logic       win_wr;
  logic [3:0] next_cnt;

  // Winner selection, evaluated every cycle but only used in IDLE.
  always_comb begin
    win = 1'b0;
    if (req0 && !req1) begin
      win = 1'b0;
    end else if (req1 && !req0) begin
      win = 1'b1;
    end else if (lock && (burst_cnt < BMAX)) begin
      win = last_owner;
    end else begin
`ifdef MEM_ARB_RR_EN
      win = ~last_owner;
`else
      win = 1'b0;
`endif
    end
  end

  always_comb begin
    win_wr   = win ? wr1 : wr0;
    next_cnt = 4'd1;
    // Same owner re-granted without an intervening idle cycle extends the burst.
    if (lock && (win == last_owner)) begin
      next_cnt = (burst_cnt >= BMAX) ? BMAX : burst_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_owner <= 1'b1;
      lock       <= 1'b0;
      burst_cnt  <= 4'd0;
      gnt0       <= 1'b0;
      gnt1       <= 1'b0;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      mem_rd     <= 1'b0;
      mem_wr     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            last_owner <= win;
            lock       <= 1'b1;
            burst_cnt  <= next_cnt;
            mem_addr   <= win ? addr1 : addr0;
            mem_wdata  <= win ? wdata1 : wdata0;
            mem_wr     <= win_wr;
            mem_rd     <= ~win_wr;
            gnt0       <= ~win;
            gnt1       <= win;
            state      <= ACCESS;
          end else begin
            lock      <= 1'b0;
            burst_cnt <= 4'd0;
          end
        end
        ACCESS: begin
          mem_rd <= 1'b0;
          mem_wr <= 1'b0;
          ack0   <= ~last_owner;
          ack1   <= last_owner;
          state  <= RESP;
        end
        RESP: begin
          ack0  <= 1'b0;
          ack1  <= 1'b0;
          gnt0  <= 1'b0;
          gnt1  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // mem_rdata is valid exactly in RESP, which is the ack cycle.
  assign rdata     = mem_rdata;
  assign dbg_state = state;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
//   Directed bench for mem_arbiter with a behavioural DataMemory model
//   (one-cycle read latency). Each scenario task drives its own stimulus and
//   checks hand-computed values; an always block checks grant/ack exclusivity.

module tb_mem_arbiter;

  localparam int AW = 7;
  localparam int DW = 8;
  localparam int BURST_MAX = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req0 = 1'b0, req1 = 1'b0;
  logic          wr0 = 1'b0, wr1 = 1'b0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0;
  logic          gnt0, gnt1, ack0, ack1;
  logic [DW-1:0] rdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_rd, mem_wr;
  logic [DW-1:0] mem_rdata = '0;
  logic [1:0]    dbg_state;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] mem_model [0:(1<<AW)-1];

  mem_arbiter #(.AW(AW), .DW(DW), .BURST_MAX(BURST_MAX)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .wr0(wr0), .wr1(wr1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .ack0(ack0), .ack1(ack1), .rdata(rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_rdata(mem_rdata), .dbg_state(dbg_state)
  );

  // ---------------- clock / memory model ----------------
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_wr) mem_model[mem_addr] <= mem_wdata;
    if (mem_rd) mem_rdata <= mem_model[mem_addr];
  end

  // Grant and ack must be mutually exclusive in every cycle.
  always @(negedge clk) begin
    if (!rst) begin
      total++;
      if ((gnt0 && gnt1) || (ack0 && ack1)) begin
        bad++;
        $display("FAIL exclusive: gnt=%b%b ack=%b%b required at most one of each",
                 gnt0, gnt1, ack0, ack1);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input bit who, input bit on, input bit wr,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (who) begin
      req1 = on; wr1 = wr; addr1 = a; wdata1 = d;
    end else begin
      req0 = on; wr0 = wr; addr0 = a; wdata0 = d;
    end
  endtask

  // Raise a request from IDLE, wait (bounded) for its ack, drop it and
  // settle back to IDLE. lat = cycles from raising req to ack, -1 on timeout.
  task automatic issue(input bit who, input bit wr, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, output logic [DW-1:0] rd, output int lat);
    rd  = 'x;
    lat = -1;
    set_req(who, 1'b1, wr, a, d);
    for (int c = 1; c <= 12; c++) begin
      step();
      if ((who ? ack1 : ack0) === 1'b1) begin
        rd  = rdata;
        lat = c;
        break;
      end
    end
    set_req(who, 1'b0, 1'b0, '0, '0);
    step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
    total++;
    if ({gnt0, gnt1, ack0, ack1, mem_rd, mem_wr} !== 6'b0) begin
      bad++;
      $display("FAIL reset_ctrl: got %b required 000000", {gnt0, gnt1, ack0, ack1, mem_rd, mem_wr});
    end
    total++;
    if (mem_addr !== 7'h00 || mem_wdata !== 8'h00) begin
      bad++;
      $display("FAIL reset_bus: got addr=%h wdata=%h required 00/00", mem_addr, mem_wdata);
    end
    total++;
    if (dbg_state !== 2'd0) begin
      bad++;
      $display("FAIL reset_state: got %0d required 0", dbg_state);
    end
  endtask

  task automatic test_read0();
    logic [DW-1:0] rd;
    int lat;
    issue(1'b0, 1'b1, 7'h05, 8'hA3, rd, lat);
    total++;
    if (lat !== 2) begin
      bad++;
      $display("FAIL wr0_latency: got %0d required 2", lat);
    end
    set_req(1'b0, 1'b1, 1'b0, 7'h05, 8'h00);
    step();  // ACCESS
    total++;
    if ({mem_rd, mem_wr, gnt0, gnt1, ack0} !== 5'b10100 || mem_addr !== 7'h05) begin
      bad++;
      $display("FAIL rd0_access: got rd/wr/g0/g1/a0=%b addr=%h required 10100 05",
               {mem_rd, mem_wr, gnt0, gnt1, ack0}, mem_addr);
    end
    step();  // RESP
    total++;
    if ({mem_rd, gnt0, gnt1, ack0, ack1} !== 5'b01010 || rdata !== 8'hA3) begin
      bad++;
      $display("FAIL rd0_resp: got rd/g0/g1/a0/a1=%b rdata=%h required 01010 a3",
               {mem_rd, gnt0, gnt1, ack0, ack1}, rdata);
    end
    set_req(1'b0, 1'b0, 1'b0, '0, '0);
    step();  // IDLE
    step();  // still IDLE, nothing requested
    total++;
    if ({gnt0, gnt1, ack0, ack1, mem_rd, mem_wr} !== 6'b0 || dbg_state !== 2'd0) begin
      bad++;
      $display("FAIL rd0_idle: got %b state=%0d required 000000 0",
               {gnt0, gnt1, ack0, ack1, mem_rd, mem_wr}, dbg_state);
    end
  endtask

  task automatic test_write_read1();
    logic [DW-1:0] rd;
    logic [DW-1:0] exp;
    int lat;
    issue(1'b1, 1'b1, 7'h7F, 8'h5C, rd, lat);
    exp_q.push_back(8'h5C);
    total++;
    if (lat !== 2) begin
      bad++;
      $display("FAIL wr1_latency: got %0d required 2", lat);
    end
    issue(1'b1, 1'b0, 7'h7F, 8'h00, rd, lat);
    exp = exp_q.pop_front();
    total++;
    if (lat !== 2 || rd !== exp) begin
      bad++;
      $display("FAIL rd1_data: got lat=%0d rdata=%h required 2 %h", lat, rd, exp);
    end
  endtask

  task automatic test_contention();
    bit order[8];
    bit exp_order[8];
    int n = 0;
`ifdef MEM_ARB_RR_EN
    exp_order = '{0, 0, 0, 0, 1, 1, 1, 1};
`else
    exp_order = '{0, 0, 0, 0, 0, 0, 0, 0};
`endif
    do_reset();  // last owner back to requester 1, lock cleared
    set_req(1'b0, 1'b1, 1'b0, 7'h01, 8'h00);
    set_req(1'b1, 1'b1, 1'b0, 7'h02, 8'h00);
    for (int c = 0; c < 60 && n < 8; c++) begin
      step();
      if (ack0 === 1'b1) begin order[n] = 1'b0; n++; end
      else if (ack1 === 1'b1) begin order[n] = 1'b1; n++; end
    end
    set_req(1'b0, 1'b0, 1'b0, '0, '0);
    set_req(1'b1, 1'b0, 1'b0, '0, '0);
    step(); step(); step();
    total++;
    if (n != 8) begin
      bad++;
      $display("FAIL contention_count: got %0d acks required 8", n);
    end
    for (int i = 0; i < 8; i++) begin
      total++;
      if (i < n && order[i] !== exp_order[i]) begin
        bad++;
        $display("FAIL contention_order[%0d]: got %0d required %0d", i, order[i], exp_order[i]);
      end
    end
  endtask

  task automatic test_reset_access();
    bit early_ack = 1'b0;
    do_reset();
    set_req(1'b0, 1'b1, 1'b1, 7'h10, 8'h33);
    step();  // ACCESS
    total++;
    if (mem_wr !== 1'b1 || mem_addr !== 7'h10) begin
      bad++;
      $display("FAIL rstacc_strobe: got wr=%b addr=%h required 1 10", mem_wr, mem_addr);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    total++;
    if ({gnt0, gnt1, ack0, ack1, mem_rd, mem_wr} !== 6'b0 || mem_addr !== 7'h00 || mem_wdata !== 8'h00) begin
      bad++;
      $display("FAIL rstacc_outputs: got %b addr=%h wdata=%h required all 0",
               {gnt0, gnt1, ack0, ack1, mem_rd, mem_wr}, mem_addr, mem_wdata);
    end
    step();  // granted again from IDLE
    if (ack0 === 1'b1) early_ack = 1'b1;
    step();
    total++;
    if (early_ack || ack0 !== 1'b1 || gnt0 !== 1'b1) begin
      bad++;
      $display("FAIL rstacc_reissue: got early=%b ack0=%b gnt0=%b required 0 1 1", early_ack, ack0, gnt0);
    end
    set_req(1'b0, 1'b0, 1'b0, '0, '0);
    step();
  endtask

  task automatic test_reset_resp();
    set_req(1'b1, 1'b1, 1'b0, 7'h7F, 8'h00);
    step();  // ACCESS
    step();  // RESP
    total++;
    if (ack1 !== 1'b1) begin
      bad++;
      $display("FAIL rstresp_ack: got %b required 1", ack1);
    end
    rst = 1'b1;
    set_req(1'b1, 1'b0, 1'b0, '0, '0);
    step();
    rst = 1'b0;
    total++;
    if ({gnt0, gnt1, ack0, ack1, mem_rd, mem_wr} !== 6'b0 || dbg_state !== 2'd0) begin
      bad++;
      $display("FAIL rstresp_outputs: got %b state=%0d required 000000 0",
               {gnt0, gnt1, ack0, ack1, mem_rd, mem_wr}, dbg_state);
    end
  endtask

  task automatic test_no_disturb();
    bit saw1 = 1'b0;
    step();
    set_req(1'b0, 1'b1, 1'b0, 7'h22, 8'h00);
    step();  // ACCESS
    addr0 = 7'h55;
    wr0   = 1'b1;
    step();  // RESP
    total++;
    if (mem_addr !== 7'h22 || ack0 !== 1'b1 || mem_wr !== 1'b0) begin
      bad++;
      $display("FAIL nodist_latched: got addr=%h ack0=%b wr=%b required 22 1 0", mem_addr, ack0, mem_wr);
    end
    set_req(1'b0, 1'b0, 1'b0, '0, '0);
    set_req(1'b1, 1'b1, 1'b0, 7'h33, 8'h00);  // raised during RESP
    step();  // IDLE
    set_req(1'b1, 1'b0, 1'b0, '0, '0);        // dropped before any grant
    for (int c = 0; c < 6; c++) begin
      step();
      if (gnt1 === 1'b1 || ack1 === 1'b1) saw1 = 1'b1;
    end
    total++;
    if (saw1) begin
      bad++;
      $display("FAIL nodist_dropped: got gnt1/ack1 activity required none");
    end
  endtask

  initial begin
    test_reset();
    test_read0();
    test_write_read1();
    test_contention();
    test_reset_access();
    test_reset_resp();
    test_no_disturb();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter AW, default 7, data-memory address width.
REQ-002 SHALL have parameter DW, default 8, data width.
REQ-003 SHALL have parameter BURST_MAX, default 4, max consecutive grants to one requester while the other waits; legal range 1..15.
REQ-004 SHALL have port clk  input  1  the single clock; all state on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have ports req0/req1  input  1  access request, requester 0 (CU_EU) / requester 1 (loader/debug).
REQ-007 SHALL have ports wr0/wr1  input  1  1=write, 0=read.
REQ-008 SHALL have ports addr0/addr1  input  AW  access address.
REQ-009 SHALL have ports wdata0/wdata1  input  DW  write data.
REQ-010 SHALL have ports gnt0/gnt1  output  1  requester owns the memory.
REQ-011 SHALL have ports ack0/ack1  output  1  one-cycle completion pulse.
REQ-012 SHALL have port rdata  output  DW  read data, combinational from mem_rdata, valid only while ackN=1 for a read.
REQ-013 SHALL have ports mem_addr (AW), mem_wdata (DW), mem_rd (1), mem_wr (1)  output  registered DataMemory drive.
REQ-014 SHALL have port mem_rdata  input  DW  DataMemory read data, valid the cycle after mem_rd.

Function
REQ-015 SHALL implement FSM IDLE -> ACCESS -> RESP -> IDLE; one access per 3 cycles.
REQ-016 IDLE with no req: SHALL stay in IDLE, clear burst_cnt to 0, clear last-owner lock.
REQ-017 IDLE with any req: SHALL select winner, latch winner's wr/addr/wdata into mem_* regs, set owner, go to ACCESS.
REQ-018 Winner, single request: that requester.
REQ-019 Winner, both requesting: last owner if burst_cnt < BURST_MAX; otherwise per REQ-034/REQ-035.
REQ-020 burst_cnt SHALL set to 1 on owner change or first grant after idle, increment on same-owner re-grant, and saturate at BURST_MAX.
REQ-021 ACCESS: SHALL assert exactly one of mem_rd/mem_wr for exactly one cycle, gnt_owner=1, then go to RESP.
REQ-022 RESP: SHALL drop mem_rd/mem_wr, keep gnt_owner=1, pulse ack_owner=1 for one cycle, then go to IDLE.
REQ-023 gnt0 and gnt1 SHALL never be high together; ack0 and ack1 SHALL never be high together.
REQ-024 Latency: req sampled high at IDLE edge N -> mem strobe in cycle N+1 -> ack in cycle N+2.
REQ-025 Requester SHALL hold req/wr/addr/wdata stable through its ack cycle; req high in the cycle after ack is a new request.
REQ-026 Inputs changing during ACCESS/RESP SHALL NOT alter the in-flight access (latched at IDLE).
REQ-027 A request dropped before grant SHALL be ignored; no ack issued.

Reset
REQ-028 rst=1 at a clock edge SHALL force state IDLE, burst_cnt=0, lock cleared, last owner=requester 1.
REQ-029 Reset values SHALL be gnt0=gnt1=0, ack0=ack1=0, mem_rd=mem_wr=0, mem_addr=0, mem_wdata=0.
REQ-030 Reset during ACCESS: the strobe already driven that cycle SHALL stand (a write may land); no ack SHALL be issued; the requester reissues.
REQ-031 Reset during RESP SHALL suppress nothing already driven that cycle; the next cycle SHALL be IDLE with all outputs at reset values.
REQ-032 rst SHALL take precedence over every other condition.

Configuration
REQ-033 Macro MEM_ARB_RR_EN SHALL select the contention policy.
REQ-034 With MEM_ARB_RR_EN defined: on contention with lock expired or absent, SHALL grant the requester that is not the last owner (round-robin).
REQ-035 Without MEM_ARB_RR_EN: on contention with lock expired or absent, SHALL grant requester 0 (fixed priority); burst lock still applies.

Verification
REQ-036 req0 read addr=7'h05, mem holds 8'hA3 -> mem_rd at N+1, mem_addr=7'h05, ack0 + rdata=8'hA3 at N+2, gnt1 never high.
REQ-037 req1 write addr=7'h7F data=8'h5C, then req1 read addr=7'h7F -> second ack1 returns 8'h5C; wrap address 7'h7F handled.
REQ-038 req0 and req1 held high continuously, BURST_MAX=4, RR_EN defined -> grant order 0,0,0,0,1,1,1,1,0...; without RR_EN -> 0,0,0,0,0... once burst_cnt saturates at 4, with requester 1 starved.
REQ-039 rst pulsed during ACCESS of a req0 write -> no ack0; next cycle all outputs 0; reissued write acked 2 cycles after IDLE grant.
REQ-040 req1 raised and dropped during req0 RESP -> no gnt1/ack1; addr0 changed mid-ACCESS -> mem_addr unchanged.
